// File: rtl/img_proc_pkg.sv
// rtl/img_proc_pkg.sv - shared encodings and helpers for the image stream processor
//   mode_e   : point-operation select values carried on cfg_mode
//   state_e  : frame sequencing states
//   comp_max : largest value of a DW-bit colour component
package img_proc_pkg;

  typedef enum logic [2:0] {
    MODE_PASS   = 3'd0,
    MODE_ADD    = 3'd1,
    MODE_SUB    = 3'd2,
    MODE_GRAY   = 3'd3,
    MODE_INVERT = 3'd4,
    MODE_THRESH = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int unsigned comp_max(input int unsigned dw);
    return (32'd1 << dw) - 32'd1;
  endfunction

endpackage

// File: rtl/img_pixel_alu.sv
// rtl/img_pixel_alu.sv - combinational per-pixel point operation
//   mode                 : operation select (6-7 behave as pass)
//   value, threshold     : brightness offset and threshold level
//   pix_r/g/b, sum       : input components and their pre-computed R+G+B
//   res_r/g/b            : processed components
module img_pixel_alu #(
  parameter int DW = 8
) (
  input  logic [2:0]    mode,
  input  logic [DW-1:0] value,
  input  logic [DW-1:0] threshold,
  input  logic [DW-1:0] pix_r,
  input  logic [DW-1:0] pix_g,
  input  logic [DW-1:0] pix_b,
  input  logic [DW+1:0] sum,
  output logic [DW-1:0] res_r,
  output logic [DW-1:0] res_g,
  output logic [DW-1:0] res_b
);
  import img_proc_pkg::*;

  localparam logic [DW-1:0] MAXV  = DW'(comp_max(DW));
  localparam logic [DW+1:0] THREE = (DW+2)'(3);

  logic [DW-1:0] gray;

  // The quotient of a (DW+2)-bit sum by 3 always fits in DW bits.
  assign gray = DW'(sum / THREE);

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] x, input logic [DW-1:0] v);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, v};
    return s[DW] ? MAXV : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] clamp_sub(input logic [DW-1:0] x, input logic [DW-1:0] v);
    return (x > v) ? (x - v) : '0;
  endfunction

  always_comb begin
    res_r = pix_r;
    res_g = pix_g;
    res_b = pix_b;
    case (mode)
      MODE_ADD: begin
        res_r = sat_add(pix_r, value);
        res_g = sat_add(pix_g, value);
        res_b = sat_add(pix_b, value);
      end
      MODE_SUB: begin
        res_r = clamp_sub(pix_r, value);
        res_g = clamp_sub(pix_g, value);
        res_b = clamp_sub(pix_b, value);
      end
      MODE_GRAY: begin
        res_r = gray;
        res_g = gray;
        res_b = gray;
      end
      MODE_INVERT: begin
        res_r = MAXV - pix_r;
        res_g = MAXV - pix_g;
        res_b = MAXV - pix_b;
      end
      MODE_THRESH: begin
        res_r = (gray > threshold) ? MAXV : '0;
        res_g = res_r;
        res_b = res_r;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/image_stream_proc.sv
// rtl/image_stream_proc.sv - two-stage streaming RGB point-operation processor
//   HCLK, HRESETn                     : clock, asynchronous active-low reset
//   start, cfg_mode/value/threshold   : frame start pulse and configuration (latched at start)
//   busy, done                        : frame in progress, end-of-frame pulse
//   in_valid/in_ready/in_r/g/b        : input pixel stream
//   out_valid/out_ready/out_r/g/b     : output pixel stream
//   out_sof/out_eol/out_eof           : frame/line markers qualifying the output pixel
module image_stream_proc #(
  parameter int DW     = 8,
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic [2:0]    cfg_mode,
  input  logic [DW-1:0] cfg_value,
  input  logic [DW-1:0] cfg_threshold,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_g,
  input  logic [DW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_g,
  output logic [DW-1:0] out_b,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof
);
  import img_proc_pkg::*;

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int CLW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0]  TOTAL_C  = CW'(TOTAL);
  localparam logic [CLW-1:0] COL_LAST = CLW'(WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(HEIGHT - 1);

  state_e        state, state_nx;
  logic [2:0]    mode_q;
  logic [DW-1:0] value_q, thr_q;
  logic [CW-1:0] in_cnt;
  logic [CLW-1:0] col;
  logic [RW-1:0] row;

  logic          s0_valid;
  logic [DW-1:0] s0_r, s0_g, s0_b;
  logic [DW+1:0] s0_sum;
  logic [DW-1:0] alu_r, alu_g, alu_b;

  logic advance, in_fire, out_fire, pipe_empty;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign advance    = !out_valid || out_ready;
  assign in_ready   = (state == ST_RUN) && advance && (in_cnt < TOTAL_C);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign pipe_empty = !s0_valid && !out_valid;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (in_cnt == TOTAL_C) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pipe_empty) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mode_q  <= '0;
      value_q <= '0;
      thr_q   <= '0;
      in_cnt  <= '0;
    end else if ((state == ST_IDLE) && start) begin
      mode_q  <= cfg_mode;
      value_q <= cfg_value;
      thr_q   <= cfg_threshold;
      in_cnt  <= '0;
    end else if (in_fire) begin
      in_cnt  <= in_cnt + 1'b1;
    end else if (done) begin
      in_cnt  <= '0;
    end
  end

  // Stage 0 registers the pixel and its component sum; stage 1 is the output register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s0_valid  <= 1'b0;
      s0_r      <= '0;
      s0_g      <= '0;
      s0_b      <= '0;
      s0_sum    <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else if (advance) begin
      s0_valid <= in_fire;
      if (in_fire) begin
        s0_r   <= in_r;
        s0_g   <= in_g;
        s0_b   <= in_b;
        s0_sum <= (DW+2)'(in_r) + (DW+2)'(in_g) + (DW+2)'(in_b);
      end
      out_valid <= s0_valid;
      if (s0_valid) begin
        out_r <= alu_r;
        out_g <= alu_g;
        out_b <= alu_b;
      end
    end
  end

  img_pixel_alu #(.DW(DW)) u_alu (
    .mode      (mode_q),
    .value     (value_q),
    .threshold (thr_q),
    .pix_r     (s0_r),
    .pix_g     (s0_g),
    .pix_b     (s0_b),
    .sum       (s0_sum),
    .res_r     (alu_r),
    .res_g     (alu_g),
    .res_b     (alu_b)
  );

  // Position of the pixel currently presented on the output.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col <= '0;
      row <= '0;
    end else if (done) begin
      col <= '0;
      row <= '0;
    end else if (out_fire) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign out_sof = out_valid && (col == '0) && (row == '0);
  assign out_eol = out_valid && (col == COL_LAST);
  assign out_eof = out_valid && (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: tb/tb_image_stream_proc.sv
// tb/tb_image_stream_proc.sv - self-checking bench for image_stream_proc
module tb_image_stream_proc;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic start = 1'b0;
  logic [2:0] cfg_mode = '0;
  logic [DW-1:0] cfg_value = '0, cfg_threshold = '0;
  logic busy, done, in_ready, out_valid, out_sof, out_eol, out_eof;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_r = '0, in_g = '0, in_b = '0;
  logic [DW-1:0] out_r, out_g, out_b;

  int checks = 0;
  int errors = 0;
  int pr[N], pg[N], pb[N];

  always #5 HCLK = ~HCLK;

  image_stream_proc #(.DW(DW), .WIDTH(W), .HEIGHT(H)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .cfg_mode(cfg_mode), .cfg_value(cfg_value), .cfg_threshold(cfg_threshold),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  // Reference: the point operation applied to one pixel, straight from the arithmetic rules.
  function automatic logic [23:0] model(input int mode, input int v, input int t,
                                        input int r, input int g, input int b);
    int c[3];
    int o[3];
    int gray;
    c[0] = r; c[1] = g; c[2] = b;
    gray = (r + g + b) / 3;
    for (int i = 0; i < 3; i++) begin
      case (mode)
        1:       o[i] = clip(c[i] + v);
        2:       o[i] = clip(c[i] - v);
        3:       o[i] = gray;
        4:       o[i] = 255 - c[i];
        5:       o[i] = (gray > t) ? 255 : 0;
        default: o[i] = c[i];
      endcase
    end
    return {8'(o[0]), 8'(o[1]), 8'(o[2])};
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      pr[i] = int'($urandom_range(0, 255));
      pg[i] = int'($urandom_range(0, 255));
      pb[i] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_markers"}, {out_sof, out_eol, out_eof}, 0);
    chk({tag, "_out_rgb"}, {out_r, out_g, out_b}, 0);
  endtask

  // rdy_pat: 0 always ready, 1 repeating 1-0-0-1, 2 random.
  // mid_at: cycle at which a stray start plus a mode change is issued (-1 none).
  // abort_after: accepted-pixel count at which reset is asserted (-1 none).
  task automatic run_frame(input string name, input int mode, input int val, input int thr,
                           input int rdy_pat, input bit gaps, input int mid_at, input int abort_after);
    logic [23:0] q_px[$];
    int q_t[$];
    int acc = 0, outs = 0, dones = 0, cyc = 0, tail = 0, t;
    bit hold_v = 1'b0;
    logic [26:0] hold_d = '0;
    logic [23:0] e;
    @(negedge HCLK);
    cfg_mode = 3'(mode); cfg_value = 8'(val); cfg_threshold = 8'(thr); start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    cfg_value = 8'($urandom); cfg_threshold = 8'($urandom);
    #1 chk({name, "_busy_after_start"}, busy, 1);
    while (cyc < 200) begin
      if (abort_after >= 0 && acc == abort_after) begin
        HRESETn = 1'b0; in_valid = 1'b0;
        #1 chk_quiet({name, "_reset"});
        @(negedge HCLK);
        HRESETn = 1'b1;
        return;
      end
      in_valid = (acc < N) && (!gaps || $urandom_range(0, 2) != 0);
      in_r = 8'(pr[(acc < N) ? acc : 0]);
      in_g = 8'(pg[(acc < N) ? acc : 0]);
      in_b = 8'(pb[(acc < N) ? acc : 0]);
      case (rdy_pat)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == mid_at) begin
        start = 1'b1;
        cfg_mode = (mode == 4) ? 3'd3 : 3'd4;
      end else begin
        start = 1'b0;
      end
      #1;
      if (hold_v) begin
        chk({name, "_stall_valid"}, out_valid, 1);
        chk({name, "_stall_hold"}, {out_sof, out_eol, out_eof, out_r, out_g, out_b}, hold_d);
      end
      hold_v = out_valid && !out_ready;
      hold_d = {out_sof, out_eol, out_eof, out_r, out_g, out_b};
      if (acc == N) chk({name, "_no_overaccept"}, in_ready, 0);
      if (in_valid && in_ready) begin
        q_px.push_back(model(mode, val, thr, pr[acc], pg[acc], pb[acc]));
        q_t.push_back(cyc);
        acc++;
      end
      if (out_valid && out_ready) begin
        if (q_px.size() == 0) begin
          chk({name, "_spurious_out"}, q_px.size(), 1);
        end else begin
          e = q_px.pop_front();
          t = q_t.pop_front();
          chk($sformatf("%s_px%0d", name, outs), {out_r, out_g, out_b}, e);
          chk($sformatf("%s_sof%0d", name, outs), out_sof, (outs == 0));
          chk($sformatf("%s_eol%0d", name, outs), out_eol, (outs % W == W - 1));
          chk($sformatf("%s_eof%0d", name, outs), out_eof, (outs == N - 1));
          if (rdy_pat == 0) chk($sformatf("%s_lat%0d", name, outs), cyc, t + 2);
        end
        outs++;
      end
      if (done) begin
        dones++;
        chk({name, "_done_after_last"}, outs, N);
      end
      if (dones > 0) tail++;
      @(negedge HCLK);
      cyc++;
      if (tail == 3) break;
    end
    start = 1'b0; in_valid = 1'b0;
    chk({name, "_out_count"}, outs, N);
    chk({name, "_done_count"}, dones, 1);
    #1 chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_in_ready"}, in_ready, 0);
  endtask

  initial begin
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    #1 chk_quiet("por");
    HRESETn = 1'b1;

    fill_rand();
    pr[0] = 30;  pg[0] = 60;  pb[0] = 90;
    pr[1] = 255; pg[1] = 255; pb[1] = 254;
    run_frame("gray", 3, 0, 0, 0, 1'b0, -1, -1);

    fill_rand();
    pr[0] = 200; pg[0] = 10; pb[0] = 155;
    run_frame("add", 1, 100, 0, 1, 1'b1, -1, -1);
    run_frame("sub", 2, 100, 0, 2, 1'b0, -1, -1);

    fill_rand();
    pr[0] = 90; pg[0] = 90; pb[0] = 93;
    pr[1] = 90; pg[1] = 90; pb[1] = 90;
    run_frame("thr", 5, 0, 90, 2, 1'b1, -1, -1);

    fill_rand();
    pr[0] = 0; pg[0] = 128; pb[0] = 255;
    run_frame("inv", 4, 0, 0, 0, 1'b0, -1, -1);

    fill_rand();
    run_frame("iso", 3, 0, 0, 1, 1'b0, 4, -1);
    fill_rand();
    run_frame("pass7", 7, 0, 0, 2, 1'b1, -1, -1);

    fill_rand();
    run_frame("abort", 1, 50, 0, 0, 1'b0, -1, 3);
    fill_rand();
    run_frame("post", 5, 0, int'($urandom_range(0, 255)), 0, 1'b0, -1, -1);

    for (int k = 0; k < 4; k++) begin
      fill_rand();
      run_frame($sformatf("rnd%0d", k), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 2, 1'b1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
